// File: rtl/btn_reset_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_reset_conditioner
// Brief    : Synchronises and debounces a raw push-button, producing a level,
//            press/release strobes and a minimum-width stretched reset.
//            Optional macro LONG_PRESS_EN adds the btn_long hold strobe.
// Revision : 1.0 - initial release
// ============================================================================
module btn_reset_conditioner #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int MIN_PULSE       = 16,
    parameter int ACTIVE_LOW_BTN  = 0,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic CLK,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic rst_out,
    output logic btn_long
);

    localparam logic [1:0]  c_st_idle         = 2'd0;
    localparam logic [1:0]  c_st_press_wait   = 2'd1;
    localparam logic [1:0]  c_st_held         = 2'd2;
    localparam logic [1:0]  c_st_release_wait = 2'd3;

    localparam logic        c_unpressed  = (ACTIVE_LOW_BTN != 0);
    localparam logic [15:0] c_deb_last   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  c_min_pulse  = 8'(MIN_PULSE);

    logic       r_s1;
    logic       r_s2;
    logic [1:0] r_state;
    logic [15:0] r_cnt;
    logic [7:0] r_pc;
    logic       r_level;
    logic       r_press;
    logic       r_release;
    logic       r_rst_out;

    logic       w_p;
    logic [1:0] w_state_nxt;
    logic [15:0] w_cnt_nxt;
    logic [7:0] w_pc_nxt;
    logic       w_level_nxt;
    logic       w_press_nxt;
    logic       w_release_nxt;
    logic       w_rst_out_nxt;

    always_comb begin
        w_p           = r_s2 ^ c_unpressed;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_level_nxt   = r_level;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_p) begin
                    w_state_nxt = c_st_press_wait;
                    w_cnt_nxt   = 16'd0;
                end
            end
            c_st_press_wait: begin
                if (!w_p) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt = c_st_held;
                    w_cnt_nxt   = 16'd0;
                    w_level_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            c_st_held: begin
                if (!w_p) begin
                    w_state_nxt = c_st_release_wait;
                    w_cnt_nxt   = 16'd0;
                end
            end
            c_st_release_wait: begin
                if (w_p) begin
                    w_state_nxt = c_st_held;
                    w_cnt_nxt   = 16'd0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_nxt   = c_st_idle;
                    w_cnt_nxt     = 16'd0;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 16'd0;
            end
        endcase

        // A press reloads the stretch counter even if a pulse is still running
        if (w_press_nxt) begin
            w_pc_nxt = c_min_pulse;
        end else if (r_pc != 8'd0) begin
            w_pc_nxt = r_pc - 8'd1;
        end else begin
            w_pc_nxt = 8'd0;
        end
        w_rst_out_nxt = w_level_nxt | (w_pc_nxt != 8'd0);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_s1      <= c_unpressed;
            r_s2      <= c_unpressed;
            r_state   <= c_st_idle;
            r_cnt     <= 16'd0;
            r_pc      <= c_min_pulse;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_rst_out <= 1'b1;
        end else begin
            r_s1      <= btn_raw;
            r_s2      <= r_s1;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_pc      <= w_pc_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_rst_out <= w_rst_out_nxt;
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign rst_out     = r_rst_out;

`ifdef LONG_PRESS_EN
    localparam logic [23:0] c_long_last = 24'(LONG_CYCLES - 1);

    logic [23:0] r_hc;
    logic [23:0] w_hc_nxt;
    logic        r_long;
    logic        w_long_nxt;
    logic        w_hc_incr;

    // Hold time accrues through release bounces; it restarts only on a new press
    always_comb begin
        w_hc_incr  = 1'b0;
        w_long_nxt = 1'b0;
        w_hc_nxt   = r_hc;
        if (w_press_nxt || (w_state_nxt == c_st_idle)) begin
            w_hc_nxt = 24'd0;
        end else if ((r_state == c_st_held) || (r_state == c_st_release_wait)) begin
            if (r_hc != 24'hFF_FFFF) begin
                w_hc_incr = 1'b1;
                w_hc_nxt  = r_hc + 24'd1;
            end
        end
        w_long_nxt = w_hc_incr && (w_hc_nxt == c_long_last);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            r_hc   <= 24'd0;
            r_long <= 1'b0;
        end else begin
            r_hc   <= w_hc_nxt;
            r_long <= w_long_nxt;
        end
    end

    assign btn_long = r_long;
`else
    assign btn_long = 1'b0;
`endif

endmodule
`default_nettype wire
